core_mem_arbiter: RTL and testbench
===================================

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

Interface
REQ-001 SHALL have parameter FAIR_LIMIT, default 4: maximum consecutive data grants while a fetch is pending.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port halt, input, 1: blocks new grants; the in-flight transfer completes.
REQ-005 SHALL have port fetch_start, input, 1: one-cycle fetch request pulse.
REQ-006 SHALL have port fetch_addr, input, ptr (30): fetch word address, sampled with fetch_start.
REQ-007 SHALL have port fetch_ready, output, 1: one-cycle fetch completion pulse.
REQ-008 SHALL have port fetch_data, output, word: fetched word, valid with fetch_ready.
REQ-009 SHALL have port data_start, input, 1: one-cycle load/store request pulse.
REQ-010 SHALL have port data_write, input, 1: store when 1, sampled with data_start.
REQ-011 SHALL have port data_addr, input, ptr: data word address, sampled with data_start.
REQ-012 SHALL have port data_wr, input, word: store data, sampled with data_start.
REQ-013 SHALL have port data_ready, output, 1: one-cycle data completion pulse.
REQ-014 SHALL have port data_rd, output, word: load result, valid with data_ready.
REQ-015 SHALL have port bus_start, output, 1: one-cycle bus transfer pulse.
REQ-016 SHALL have port bus_write, output, 1: bus write strobe, valid with bus_start.
REQ-017 SHALL have port bus_addr, output, ptr: bus address, held from bus_start until bus_ready.
REQ-018 SHALL have port bus_data_wr, output, word: bus write data, held from bus_start until bus_ready.
REQ-019 SHALL have port bus_ready, input, 1: bus completion pulse.
REQ-020 SHALL have port bus_data_rd, input, word: bus read data, valid with bus_ready.
REQ-021 SHALL have port busy, output, 1: high when a request is pending or a transfer is in flight.

Function
REQ-022 SHALL latch each *_start into a per-requester pending slot (address, write flag, data); one slot per requester.
REQ-023 SHALL ignore a *_start from a requester whose slot is already pending or in flight, except in the cycle of that requester's own ready pulse, when it SHALL be accepted.
REQ-024 SHALL implement states IDLE, FETCH and DATA; IDLE -> FETCH/DATA on grant; FETCH/DATA -> IDLE on bus_ready.
REQ-025 SHALL grant only from IDLE with halt=0, at earliest the cycle after the request is latched; bus_start SHALL pulse in the cycle of entry to FETCH/DATA.
REQ-026 SHALL prioritise data over fetch, except that fetch wins when the fairness counter equals FAIR_LIMIT.
REQ-027 SHALL increment the fairness counter on each data grant made while a fetch is pending, clear it on each fetch grant, and saturate it at FAIR_LIMIT.
REQ-028 SHALL drive bus_write=0 for fetch transfers.
REQ-029 SHALL forward bus_ready to the owner's ready output combinationally in the same cycle, with bus_data_rd passed to the owner's data output; the non-owner's ready SHALL stay 0.
REQ-030 SHALL ignore bus_ready in IDLE.
REQ-031 SHALL hold fetch_data and data_rd at their last value outside ready cycles.
REQ-032 SHALL keep a minimum turnaround of one IDLE cycle between bus_ready and the next bus_start.

Reset
REQ-033 SHALL, on rst_n low, asynchronously enter IDLE, clear both slots and the fairness counter, and drive bus_start, fetch_ready, data_ready and busy to 0 and all data/address outputs to 0.
REQ-034 SHALL, after reset mid-transfer, discard the lost transfer and raise no ready pulse for it.

Structure
REQ-035 SHALL place the state enum (IDLE/FETCH/DATA) in the shared uarch package; ptr and word SHALL come from that package.
REQ-036 SHALL use one sub-module, core_mem_arbiter_slot, instantiated once per requester, to hold the pending request.

Verification
REQ-037 Isolated fetch: fetch_start with addr 0x100 at cycle 0 -> bus_start with bus_addr 0x100 and bus_write 0 at cycle 1; bus_ready with 0xDEADBEEF -> fetch_ready=1 and fetch_data=0xDEADBEEF in the same cycle.
REQ-038 Simultaneous requests: fetch_start and a store to 0x20 with data 0x55 in the same cycle -> data granted first; fetch bus_start one cycle after the data bus_ready.
REQ-039 Fairness: fetch pending while data restarts continuously -> exactly 4 data grants, then a fetch grant, then the counter is 0.
REQ-040 Halt: halt=1 during a data transfer -> that transfer completes; no bus_start while halt=1; the pending fetch is granted the cycle after halt falls.
REQ-041 Reset mid-transfer: rst_n low during FETCH -> all outputs 0 immediately; a later bus_ready produces no fetch_ready.

Source files
------------

// File: rtl/core_mem_arbiter_pkg.sv
// Shared micro-architecture types for the core memory arbiter.
//   ptr / word       : bus address (word granular) and data types
//   arb_state_e      : arbiter bus-ownership state
//   mem_req_t        : one latched request (address, write flag, store data)
package core_mem_arbiter_pkg;
  localparam int PTR_W  = 30;
  localparam int WORD_W = 32;

  typedef logic [PTR_W-1:0]  ptr;
  typedef logic [WORD_W-1:0] word;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_e;

  typedef struct packed {
    ptr   addr;
    logic write;
    word  data;
  } mem_req_t;
endpackage

// File: rtl/core_mem_arbiter_slot.sv
// Per-requester pending slot.
//   start/write/addr/data : request pulse and its sampled payload
//   grant                 : arbiter picked this slot (pending -> in flight)
//   done                  : ready pulse for this requester (in flight -> free)
//   pending/in_flight/req : slot status and held request
module core_mem_arbiter_slot
  import core_mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              write,
  input  logic [PTR_W-1:0]  addr,
  input  logic [WORD_W-1:0] data,
  input  logic              grant,
  input  logic              done,
  output logic              pending,
  output logic              in_flight,
  output mem_req_t          req
);
  // A busy slot drops new starts, except on its own ready cycle, so a
  // requester can chain back-to-back accesses without a dead cycle.
  logic accept;
  assign accept = start && (!(pending || in_flight) || done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= 1'b0;
      in_flight <= 1'b0;
      req       <= '0;
    end else if (accept) begin
      pending   <= 1'b1;
      in_flight <= 1'b0;
      req       <= '{addr: addr, write: write, data: data};
    end else if (grant) begin
      pending   <= 1'b0;
      in_flight <= 1'b1;
    end else if (done) begin
      in_flight <= 1'b0;
    end
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter onto a single memory bus.
//   halt                          : blocks new grants, in-flight transfer completes
//   fetch_start/addr -> fetch_ready/data : fetch request and completion
//   data_start/write/addr/wr -> data_ready/rd : load/store request and completion
//   bus_start/write/addr/data_wr, bus_ready/data_rd : memory bus
//   busy                          : any request pending or transfer in flight
// Data wins arbitration unless FAIR_LIMIT data grants have been made back to
// back while a fetch waited, in which case the fetch goes next.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int FAIR_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              fetch_start,
  input  logic [PTR_W-1:0]  fetch_addr,
  output logic              fetch_ready,
  output logic [WORD_W-1:0] fetch_data,
  input  logic              data_start,
  input  logic              data_write,
  input  logic [PTR_W-1:0]  data_addr,
  input  logic [WORD_W-1:0] data_wr,
  output logic              data_ready,
  output logic [WORD_W-1:0] data_rd,
  output logic              bus_start,
  output logic              bus_write,
  output logic [PTR_W-1:0]  bus_addr,
  output logic [WORD_W-1:0] bus_data_wr,
  input  logic              bus_ready,
  input  logic [WORD_W-1:0] bus_data_rd,
  output logic              busy
);
  localparam int CNT_W = $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FAIR_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] fair_cnt_q;
  logic             f_pend, f_fly, d_pend, d_fly;
  mem_req_t         f_req, d_req;
  logic             grant_f, grant_d, fetch_turn;
  word              fetch_data_q, data_rd_q;

  // Fetch never writes: its slot is tied to a read with zero data.
  core_mem_arbiter_slot u_fetch_slot (
    .clk(clk), .rst_n(rst_n),
    .start(fetch_start), .write(1'b0), .addr(fetch_addr), .data('0),
    .grant(grant_f), .done(fetch_ready),
    .pending(f_pend), .in_flight(f_fly), .req(f_req)
  );

  core_mem_arbiter_slot u_data_slot (
    .clk(clk), .rst_n(rst_n),
    .start(data_start), .write(data_write), .addr(data_addr), .data(data_wr),
    .grant(grant_d), .done(data_ready),
    .pending(d_pend), .in_flight(d_fly), .req(d_req)
  );

  // Grant is decided combinationally in IDLE so bus_start lands in the
  // cycle the transfer begins; the IDLE cycle after bus_ready is the
  // turnaround.
  assign fetch_turn = f_pend && (!d_pend || fair_cnt_q == CNT_MAX);
  assign grant_f    = (state_q == IDLE) && !halt && fetch_turn;
  assign grant_d    = (state_q == IDLE) && !halt && d_pend && !fetch_turn;
  assign bus_start  = grant_f || grant_d;

  assign fetch_ready = (state_q == FETCH) && bus_ready;
  assign data_ready  = (state_q == DATA)  && bus_ready;
  assign fetch_data  = fetch_ready ? bus_data_rd : fetch_data_q;
  assign data_rd     = data_ready  ? bus_data_rd : data_rd_q;

  assign busy = f_pend || f_fly || d_pend || d_fly || (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_f) state_d = FETCH;
               else if (grant_d) state_d = DATA;
      FETCH,
      DATA:    if (bus_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus payload follows the owner's slot, which stays untouched until the
  // ready cycle, so address/data hold for the whole transfer.
  always_comb begin
    bus_write   = 1'b0;
    bus_addr    = '0;
    bus_data_wr = '0;
    if (grant_f || state_q == FETCH) begin
      bus_write   = f_req.write;
      bus_addr    = f_req.addr;
      bus_data_wr = f_req.data;
    end else if (grant_d || state_q == DATA) begin
      bus_write   = d_req.write;
      bus_addr    = d_req.addr;
      bus_data_wr = d_req.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fair_cnt_q   <= '0;
      fetch_data_q <= '0;
      data_rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_f)
        fair_cnt_q <= '0;
      else if (grant_d && f_pend && fair_cnt_q != CNT_MAX)
        fair_cnt_q <= fair_cnt_q + 1'b1;
      if (fetch_ready) fetch_data_q <= bus_data_rd;
      if (data_ready)  data_rd_q    <= bus_data_rd;
    end
  end
endmodule

// File: tb/tb_core_mem_arbiter.sv
module tb_core_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, fetch_start, data_start, data_write, bus_ready;
  logic [29:0] fetch_addr, data_addr;
  logic [31:0] data_wr, bus_data_rd;
  logic        fetch_ready, data_ready, bus_start, bus_write, busy;
  logic [31:0] fetch_data, data_rd, bus_data_wr;
  logic [29:0] bus_addr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_mem_arbiter #(.FAIR_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .fetch_start(fetch_start), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .data_start(data_start), .data_write(data_write), .data_addr(data_addr),
    .data_wr(data_wr), .data_ready(data_ready), .data_rd(data_rd),
    .bus_start(bus_start), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_data_wr(bus_data_wr), .bus_ready(bus_ready),
    .bus_data_rd(bus_data_rd), .busy(busy)
  );

  typedef struct {
    logic halt, fs; logic [29:0] fa;
    logic ds, dw; logic [29:0] da; logic [31:0] dwr;
    logic br; logic [31:0] brd;
    logic e_bs, e_bw, chk_bus; logic [29:0] e_ba; logic [31:0] e_bwd;
    logic e_fr; logic [31:0] e_fd; logic e_dr; logic [31:0] e_drd; logic e_busy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic h, logic fs, logic [29:0] fa, logic ds, logic dw, logic [29:0] da,
    logic [31:0] dwr, logic br, logic [31:0] brd,
    logic bs, logic bw, logic cb, logic [29:0] ba, logic [31:0] bwd,
    logic fr, logic [31:0] fd, logic dr, logic [31:0] drd, logic by);
    vec_t v;
    v.halt = h; v.fs = fs; v.fa = fa; v.ds = ds; v.dw = dw; v.da = da;
    v.dwr = dwr; v.br = br; v.brd = brd;
    v.e_bs = bs; v.e_bw = bw; v.chk_bus = cb; v.e_ba = ba; v.e_bwd = bwd;
    v.e_fr = fr; v.e_fd = fd; v.e_dr = dr; v.e_drd = drd; v.e_busy = by;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    halt = 0; fetch_start = 0; fetch_addr = '0; data_start = 0; data_write = 0;
    data_addr = '0; data_wr = '0; bus_ready = 0; bus_data_rd = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // 3 units later, well clear of the next edge.
  task automatic tick();
    @(posedge clk); #1;
    clr_in();
  endtask

  initial begin
    // halt fs fa      ds dw da     dwr   br brd          | bs bw cb ba     bwd   fr fd           dr drd          busy
    vq.push_back(mk(0,1,30'h100,0,0,30'h0, 32'h0, 0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'h0,        0,32'h0,        0));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        1,0,1,30'h100,32'h0, 0,32'h0,        0,32'h0,        1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        0,0,1,30'h100,32'h0, 0,32'h0,        0,32'h0,        1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 1,32'hDEADBEEF, 0,0,1,30'h100,32'h0, 1,32'hDEADBEEF, 0,32'h0,        1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'hDEADBEEF, 0,32'h0,        0));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 1,32'h1234,     0,0,0,30'h0,  32'h0, 0,32'hDEADBEEF, 0,32'h0,        0));
    vq.push_back(mk(0,1,30'h40, 1,1,30'h20,32'h55,0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'hDEADBEEF, 0,32'h0,        0));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        1,1,1,30'h20, 32'h55,0,32'hDEADBEEF, 0,32'h0,        1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 1,32'h0,        0,0,1,30'h20, 32'h55,0,32'hDEADBEEF, 1,32'h0,        1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        1,0,1,30'h40, 32'h0, 0,32'hDEADBEEF, 0,32'h0,        1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 1,32'hCAFEF00D, 0,0,1,30'h40, 32'h0, 1,32'hCAFEF00D, 0,32'h0,        1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'hCAFEF00D, 0,32'h0,        0));
    vq.push_back(mk(0,0,30'h0,  1,0,30'h30,32'h0, 0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'hCAFEF00D, 0,32'h0,        0));
    vq.push_back(mk(0,1,30'h80, 0,0,30'h0, 32'h0, 0,32'h0,        1,0,1,30'h30, 32'h0, 0,32'hCAFEF00D, 0,32'h0,        1));
    vq.push_back(mk(1,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        0,0,1,30'h30, 32'h0, 0,32'hCAFEF00D, 0,32'h0,        1));
    vq.push_back(mk(1,0,30'h0,  0,0,30'h0, 32'h0, 1,32'h11223344, 0,0,1,30'h30, 32'h0, 0,32'hCAFEF00D, 1,32'h11223344, 1));
    vq.push_back(mk(1,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'hCAFEF00D, 0,32'h11223344, 1));
    vq.push_back(mk(1,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'hCAFEF00D, 0,32'h11223344, 1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        1,0,1,30'h80, 32'h0, 0,32'hCAFEF00D, 0,32'h11223344, 1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 1,32'h99,       0,0,1,30'h80, 32'h0, 1,32'h99,       0,32'h11223344, 1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'h99,       0,32'h11223344, 0));
    vq.push_back(mk(0,1,30'h200,0,0,30'h0, 32'h0, 0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'h99,       0,32'h11223344, 0));
    vq.push_back(mk(0,1,30'h300,0,0,30'h0, 32'h0, 0,32'h0,        1,0,1,30'h200,32'h0, 0,32'h99,       0,32'h11223344, 1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 1,32'h1,        0,0,1,30'h200,32'h0, 1,32'h1,        0,32'h11223344, 1));
    vq.push_back(mk(0,0,30'h0,  0,0,30'h0, 32'h0, 0,32'h0,        0,0,0,30'h0,  32'h0, 0,32'h1,        0,32'h11223344, 0));

    // Reset state
    clr_in();
    rst_n = 0;
    #2;
    chk("rst bus_start", 32'(bus_start), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst fetch_ready", 32'(fetch_ready), 32'h0);
    chk("rst data_ready", 32'(data_ready), 32'h0);
    chk("rst bus_addr", 32'(bus_addr), 32'h0);
    chk("rst fetch_data", fetch_data, 32'h0);
    chk("rst data_rd", data_rd, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // Table vectors: one row per cycle
    foreach (vq[i]) begin
      tick();
      halt = vq[i].halt; fetch_start = vq[i].fs; fetch_addr = vq[i].fa;
      data_start = vq[i].ds; data_write = vq[i].dw; data_addr = vq[i].da;
      data_wr = vq[i].dwr; bus_ready = vq[i].br; bus_data_rd = vq[i].brd;
      #3;
      chk($sformatf("row%0d bus_start", i), 32'(bus_start), 32'(vq[i].e_bs));
      if (vq[i].e_bs)
        chk($sformatf("row%0d bus_write", i), 32'(bus_write), 32'(vq[i].e_bw));
      if (vq[i].chk_bus) begin
        chk($sformatf("row%0d bus_addr", i), 32'(bus_addr), 32'(vq[i].e_ba));
        chk($sformatf("row%0d bus_data_wr", i), bus_data_wr, vq[i].e_bwd);
      end
      chk($sformatf("row%0d fetch_ready", i), 32'(fetch_ready), 32'(vq[i].e_fr));
      chk($sformatf("row%0d fetch_data", i), fetch_data, vq[i].e_fd);
      chk($sformatf("row%0d data_ready", i), 32'(data_ready), 32'(vq[i].e_dr));
      chk($sformatf("row%0d data_rd", i), data_rd, vq[i].e_drd);
      chk($sformatf("row%0d busy", i), 32'(busy), 32'(vq[i].e_busy));
    end

    // Fairness: fetch waits while data restarts on every data_ready
    tick();
    fetch_start = 1; fetch_addr = 30'h400;
    data_start = 1; data_addr = 30'h10;
    #3;
    for (int g = 0; g < 4; g++) begin
      tick(); #3;
      chk($sformatf("fair grant%0d bus_start", g), 32'(bus_start), 32'h1);
      chk($sformatf("fair grant%0d bus_addr", g), 32'(bus_addr), 32'h10 + 32'(g));
      tick();
      bus_ready = 1; bus_data_rd = 32'h1000 + 32'(g);
      data_start = 1; data_addr = 30'h11 + 30'(g);
      #3;
      chk($sformatf("fair ready%0d data_ready", g), 32'(data_ready), 32'h1);
      chk($sformatf("fair ready%0d data_rd", g), data_rd, 32'h1000 + 32'(g));
      chk($sformatf("fair ready%0d fetch_ready", g), 32'(fetch_ready), 32'h0);
    end
    tick(); #3;
    chk("fair cnt at limit", 32'(dut.fair_cnt_q), 32'h4);
    chk("fair fetch bus_start", 32'(bus_start), 32'h1);
    chk("fair fetch bus_addr", 32'(bus_addr), 32'h400);
    chk("fair fetch bus_write", 32'(bus_write), 32'h0);
    tick();
    bus_ready = 1; bus_data_rd = 32'h77;
    #3;
    chk("fair cnt cleared", 32'(dut.fair_cnt_q), 32'h0);
    chk("fair fetch_ready", 32'(fetch_ready), 32'h1);
    chk("fair fetch_data", fetch_data, 32'h77);
    tick(); #3;
    chk("fair data resume bus_start", 32'(bus_start), 32'h1);
    chk("fair data resume bus_addr", 32'(bus_addr), 32'h14);
    tick();
    bus_ready = 1; bus_data_rd = 32'h88;
    #3;
    chk("fair last data_ready", 32'(data_ready), 32'h1);
    tick(); #3;
    chk("fair idle busy", 32'(busy), 32'h0);

    // Reset in the middle of a fetch transfer
    tick();
    fetch_start = 1; fetch_addr = 30'h500;
    #3;
    tick(); #3;
    chk("mrst grant bus_start", 32'(bus_start), 32'h1);
    tick();
    rst_n = 0;
    #1;
    chk("mrst bus_start", 32'(bus_start), 32'h0);
    chk("mrst busy", 32'(busy), 32'h0);
    chk("mrst bus_addr", 32'(bus_addr), 32'h0);
    chk("mrst fetch_data", fetch_data, 32'h0);
    chk("mrst data_rd", data_rd, 32'h0);
    tick();
    rst_n = 1;
    #3;
    tick();
    bus_ready = 1; bus_data_rd = 32'hBAD0;
    #3;
    chk("mrst late fetch_ready", 32'(fetch_ready), 32'h0);
    chk("mrst late fetch_data", fetch_data, 32'h0);
    chk("mrst late busy", 32'(busy), 32'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
